// File: rtl/scan_decoder_pkg.sv
// Shared types for the scan decoder: controller states and mode encodings.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        OFF,
        DIRECT,
        SCAN
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decode.sv
// Combinational N-to-2**N one-hot decoder.
module onehot_decode #(
    parameter int N = 3
) (
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] dec
);

    // NOTE: dec gets a full default before the indexed write so no latch is inferred.
    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a direct-select mode and a dwell-timed auto-scan mode.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int N     = 3,
    parameter  int DWELL = 4,
    localparam int OUTS  = 2**N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e,
    input  logic            mode,
    input  logic [N-1:0]    in,
    output logic [OUTS-1:0] out,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int             DW         = $clog2(DWELL + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]   IDX_LAST   = N'(OUTS - 1);

    state_e          state_q, state_d;
    logic [OUTS-1:0] out_q, out_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [OUTS-1:0] dec_onehot;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = '0;
        wrap_d  = 1'b0;

        if (!e) begin
            state_d = OFF;
        end else if (mode == MODE_SCAN) begin
            state_d = SCAN;
        end else begin
            state_d = DIRECT;
        end

        case (state_d)
            DIRECT: idx_d = in;
            SCAN: begin
                // Entering scan latches the start index; afterwards in is ignored.
                if (state_q != SCAN) begin
                    idx_d = in;
                end else if (dwell_q == DWELL_LAST) begin
                    idx_d  = idx_q + N'(1);
                    wrap_d = (idx_q == IDX_LAST);
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: idx_d = idx_q;
        endcase
    end

    // The out register is decoded from the next index so out and idx stay aligned.
    onehot_decode #(.N(N)) u_onehot_decode (
        .sel (idx_d),
        .dec (dec_onehot)
    );

    assign out_d = (state_d == OFF) ? '0 : dec_onehot;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            out_q   <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: two decoders (DWELL=2 and DWELL=1) driven in lockstep against a scan-position model.
module tb_scan_decoder;

    logic       clk;
    logic       rst;
    logic       e;
    logic       mode;
    logic [2:0] in_s;
    logic [7:0] out_a, out_b;
    logic [2:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    // Model: 0=off, 1=direct, 2=scan; scan index derived from start + elapsed/dwell.
    int dw[2] = '{2, 1};
    int m_state[2];
    int m_start[2];
    int m_elapsed[2];
    int m_idx[2];
    int m_out[2];
    int m_wrap[2];

    scan_decoder #(.N(3), .DWELL(2)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .mode (mode),
        .in   (in_s),
        .out  (out_a),
        .idx  (idx_a),
        .wrap (wrap_a)
    );

    scan_decoder #(.N(3), .DWELL(1)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .mode (mode),
        .in   (in_s),
        .out  (out_b),
        .idx  (idx_b),
        .wrap (wrap_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] exp_vec(int k);
        int o, i, w;
        o = m_out[k];
        i = m_idx[k];
        w = m_wrap[k];
        return {o[7:0], i[2:0], w[0]};
    endfunction

    function automatic logic [11:0] act_vec(int k);
        return (k == 0) ? {out_a, idx_a, wrap_a} : {out_b, idx_b, wrap_b};
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_state[k] = 0; m_idx[k] = 0; m_out[k] = 0; m_wrap[k] = 0;
            end else if (!e) begin
                m_state[k] = 0; m_out[k] = 0; m_wrap[k] = 0;
            end else if (!mode) begin
                m_state[k] = 1; m_idx[k] = int'(in_s); m_out[k] = 1 << in_s; m_wrap[k] = 0;
            end else if (m_state[k] != 2) begin
                m_state[k] = 2; m_start[k] = int'(in_s); m_elapsed[k] = 0;
                m_idx[k] = int'(in_s); m_out[k] = 1 << in_s; m_wrap[k] = 0;
            end else begin
                m_elapsed[k]++;
                m_idx[k]  = (m_start[k] + m_elapsed[k] / dw[k]) % 8;
                m_wrap[k] = ((m_elapsed[k] % dw[k]) == 0 && m_idx[k] == 0) ? 1 : 0;
                m_out[k]  = 1 << m_idx[k];
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; e = 1'b1; mode = 1'b1; in_s = 3'($urandom);
        step();
        step();
        checks++;
        if (out_a !== 8'h00 || idx_a !== 3'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got out=%h idx=%0d wrap=%b exp out=00 idx=0 wrap=0", out_a, idx_a, wrap_a);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL reset_model[%0d]: got %h exp %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_direct_sweep();
        logic [7:0] exp_o;
        rst = 1'b1; step();
        rst = 1'b0; e = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_s = 3'(i);
            step();
            exp_o = 8'h01 << i;
            checks++;
            if (out_a !== exp_o || idx_a !== 3'(i) || wrap_a !== 1'b0) begin
                errors++;
                $display("FAIL direct_sweep[%0d]: got out=%h idx=%0d wrap=%b exp out=%h idx=%0d wrap=0",
                         i, out_a, idx_a, wrap_a, exp_o, i);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL direct_model[%0d]: got %h exp %h", k, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_scan_wrap();
        logic [7:0] out_seq [7] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
        logic       wrap_seq[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst = 1'b1; step();
        rst = 1'b0; e = 1'b1; mode = 1'b1; in_s = 3'd6;
        for (int i = 0; i < 7; i++) begin
            step();
            in_s = 3'($urandom);
            checks++;
            if (out_a !== out_seq[i] || wrap_a !== wrap_seq[i]) begin
                errors++;
                $display("FAIL scan_wrap[%0d]: got out=%h wrap=%b exp out=%h wrap=%b",
                         i, out_a, wrap_a, out_seq[i], wrap_seq[i]);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL scan_wrap_model[%0d]: got %h exp %h", k, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_dwell1();
        logic [7:0] exp_o;
        logic       exp_w;
        rst = 1'b1; step();
        rst = 1'b0; e = 1'b1; mode = 1'b1; in_s = 3'd0;
        for (int i = 0; i < 24; i++) begin
            step();
            in_s  = 3'($urandom);
            exp_o = 8'h01 << (i % 8);
            exp_w = (i > 0 && (i % 8) == 0);
            checks++;
            if (out_b !== exp_o || wrap_b !== exp_w) begin
                errors++;
                $display("FAIL dwell1[%0d]: got out=%h wrap=%b exp out=%h wrap=%b", i, out_b, wrap_b, exp_o, exp_w);
            end
            checks++;
            if (act_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL dwell1_model_a: got %h exp %h", act_vec(0), exp_vec(0));
            end
        end
    endtask

    task automatic test_enable_drop();
        rst = 1'b1; step();
        rst = 1'b0; e = 1'b1; mode = 1'b1; in_s = 3'd0;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (idx_a !== 3'd3 || out_a !== 8'h08) begin
            errors++;
            $display("FAIL en_drop_pre: got idx=%0d out=%h exp idx=3 out=08", idx_a, out_a);
        end
        e = 1'b0; in_s = 3'd1;
        step();
        checks++;
        if (out_a !== 8'h00 || idx_a !== 3'd3 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_off: got out=%h idx=%0d wrap=%b exp out=00 idx=3 wrap=0", out_a, idx_a, wrap_a);
        end
        e = 1'b1; in_s = 3'd5;
        step();
        checks++;
        if (out_a !== 8'h20 || idx_a !== 3'd5) begin
            errors++;
            $display("FAIL en_drop_restart: got out=%h idx=%0d exp out=20 idx=5", out_a, idx_a);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL en_drop_model[%0d]: got %h exp %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_reset_mid_dwell();
        logic [2:0] start;
        rst = 1'b1; step();
        rst = 1'b0; e = 1'b1; mode = 1'b1; in_s = 3'($urandom);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (out_a !== 8'h00 || idx_a !== 3'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got out=%h idx=%0d wrap=%b exp out=00 idx=0 wrap=0", out_a, idx_a, wrap_a);
        end
        start = 3'($urandom);
        rst = 1'b0; in_s = start;
        step();
        checks++;
        if (out_a !== (8'h01 << start) || idx_a !== start) begin
            errors++;
            $display("FAIL rst_mid_release: got out=%h idx=%0d exp out=%h idx=%0d",
                     out_a, idx_a, 8'h01 << start, start);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL rst_mid_model[%0d]: got %h exp %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_mode_toggle();
        rst = 1'b1; step();
        rst = 1'b0; e = 1'b1; mode = 1'b1; in_s = 3'd7;
        step();
        step();
        // Dwell-2 unit is at idx 7 with the wrap advance due next edge.
        mode = 1'b0; in_s = 3'd2;
        step();
        checks++;
        if (out_a !== 8'h04 || idx_a !== 3'd2 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL mode_toggle: got out=%h idx=%0d wrap=%b exp out=04 idx=2 wrap=0", out_a, idx_a, wrap_a);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL mode_toggle_model[%0d]: got %h exp %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            e    = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_s = 3'($urandom);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random[%0d][%0d]: got %h exp %h", i, k, act_vec(k), exp_vec(k));
                end
            end
            checks++;
            if (out_a !== 8'h00 && out_a !== (8'h01 << idx_a)) begin
                errors++;
                $display("FAIL onehot[%0d]: got out=%h idx=%0d exp zero or onehot(idx)", i, out_a, idx_a);
            end
        end
    endtask

    initial begin
        rst = 1'b1; e = 1'b0; mode = 1'b0; in_s = 3'd0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_start[k] = 0; m_elapsed[k] = 0;
            m_idx[k] = 0; m_out[k] = 0; m_wrap[k] = 0;
        end
        #1;
        test_reset();
        test_direct_sweep();
        test_scan_wrap();
        test_dwell1();
        test_enable_drop();
        test_reset_mid_dwell();
        test_mode_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
